// File: rtl/lsu_mem_ctrl.sv
// RISC-V load/store unit: turns byte-addressed loads/stores into word accesses on a
// lane-masked data memory, splitting misaligned accesses and merging sub-word stores.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  wmem,
    output logic [4:0]  rmem,
    output logic [31:0] mem_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] word_a_q, word_a_d, word_b_q, word_b_d;
    logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d, mem_addr_q, mem_addr_d, store_data_q, store_data_d;
    logic [3:0]  wmem_q, wmem_d;
    logic [4:0]  rmem_q, rmem_d;

    logic        accept, span, direct, aligned_sw, bad_f3, bad_range, err;
    logic [1:0]  off;
    logic [29:0] wa;
    logic [2:0]  nbytes;
    logic [3:0]  bmask, lane4;
    logic [7:0]  lane8;
    logic [30:0] last_word;
    logic [31:0] rd_a, rd_b, ld_val;
    logic [63:0] pair, shifted, wmask64, wdata64, merged;

    // Request latch, access geometry and legality
    always_comb begin
        accept  = req_valid & req_ready_q;
        we_d    = accept ? req_we     : we_q;
        f3_d    = accept ? req_funct3 : f3_q;
        addr_d  = accept ? req_addr   : addr_q;
        wdata_d = accept ? req_wdata  : wdata_q;

        off = addr_d[1:0];
        wa  = addr_d[31:2];
        unique case (f3_d[1:0])
            2'b00:   begin nbytes = 3'd1; bmask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; bmask = 4'b0011; end
            default: begin nbytes = 3'd4; bmask = 4'b1111; end
        endcase
        lane4      = bmask << off;
        span       = (3'(off) + nbytes) > 3'd4;
        direct     = (f3_d[1:0] == 2'b00) || ((f3_d[1:0] == 2'b01) && !off[0]) || (off == 2'b00);
        aligned_sw = (f3_d[1:0] == 2'b10) && (off == 2'b00);
        bad_f3     = we_d ? (f3_d[2] || (f3_d[1:0] == 2'b11))
                          : ((f3_d[1:0] == 2'b11) || (f3_d == 3'b110));
        last_word  = {1'b0, wa} + 31'(span);
        bad_range  = (last_word >> ADDR_WIDTH) != 31'd0;
        err        = bad_f3 | bad_range;
    end

    // Word buffers, load assembly and store merge over the two-word window {B, A}
    always_comb begin
        rd_a     = (state_q == S_RD_A) ? load_data : word_a_q;
        rd_b     = (state_q == S_RD_B) ? load_data : word_b_q;
        word_a_d = rd_a;
        word_b_d = rd_b;
        pair     = {rd_b, rd_a};
        shifted  = pair >> {off, 3'b000};
        unique case (f3_d)
            3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_val = {24'd0, shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_val = {16'd0, shifted[15:0]};
            default: ld_val = shifted[31:0];
        endcase
        lane8 = 8'(bmask) << off;
        for (int i = 0; i < 8; i++) begin
            wmask64[8*i +: 8] = {8{lane8[i]}};
        end
        wdata64 = (64'(wdata_d) << {off, 3'b000}) & wmask64;
        merged  = (pair & ~wmask64) | wdata64;
    end

    // Next state and registered outputs decoded from the next state
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        wmem_d       = 4'd0;
        rmem_d       = 5'd0;
        mem_addr_d   = 32'd0;
        store_data_d = 32'd0;

        unique case (state_q)
            S_IDLE: if (accept) begin
                if (err)        state_d = S_RESP;
                else if (!we_d) state_d = direct ? S_LD : S_RD_A;
                else            state_d = aligned_sw ? S_WR_A : S_RD_A;
            end
            S_LD:    state_d = S_RESP;
            S_RD_A:  state_d = span ? S_RD_B : (we_q ? S_WR_A : S_RESP);
            S_RD_B:  state_d = we_q ? S_WR_A : S_RESP;
            S_WR_A:  state_d = span ? S_WR_B : S_RESP;
            S_WR_B:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        unique case (state_d)
            S_LD: begin
                rmem_d     = {~f3_d[2] & (f3_d[1:0] != 2'b10), lane4};
                mem_addr_d = {2'b00, wa};
            end
            S_RD_A: begin
                rmem_d     = 5'b01111;
                mem_addr_d = {2'b00, wa};
            end
            S_RD_B: begin
                rmem_d     = 5'b01111;
                mem_addr_d = {2'b00, wa} + 32'd1;
            end
            S_WR_A: begin
                wmem_d       = 4'b1111;
                mem_addr_d   = {2'b00, wa};
                store_data_d = merged[31:0];
            end
            S_WR_B: begin
                wmem_d       = 4'b1111;
                mem_addr_d   = {2'b00, wa} + 32'd1;
                store_data_d = merged[63:32];
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_err_d   = err;
                if (!err && !we_d) resp_rdata_d = (state_q == S_LD) ? load_data : ld_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            word_a_q     <= 32'd0;
            word_b_q     <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            wmem_q       <= 4'd0;
            rmem_q       <= 5'd0;
            mem_addr_q   <= 32'd0;
            store_data_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_a_q     <= word_a_d;
            word_b_q     <= word_b_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            wmem_q       <= wmem_d;
            rmem_q       <= rmem_d;
            mem_addr_q   <= mem_addr_d;
            store_data_q <= store_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign wmem       = wmem_q;
    assign rmem       = rmem_q;
    assign mem_addr   = mem_addr_q;
    assign store_data = store_data_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: lane-masked memory model on the DUT side and a
// byte-level reference model that predicts load data, error and response latency.
module tb_lsu_mem_ctrl;
    localparam int AW = 15;
    localparam int NW = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, store_data;
    logic [31:0] load_data = 32'd0;
    logic [3:0]  wmem;
    logic [4:0]  rmem;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem     [0:NW-1];
    logic [31:0] ref_mem [0:NW-1];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    lsu_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .wmem(wmem), .rmem(rmem), .mem_addr(mem_addr), .store_data(store_data),
        .load_data(load_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory returns the selected lanes shifted down, sign-extended when rmem[4] is set
    function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [4:0] rm);
        int lo = 0;
        int cnt = 0;
        logic [31:0] v;
        for (int i = 3; i >= 0; i--) if (rm[i]) lo = i;
        for (int i = 0; i < 4; i++) if (rm[i]) cnt++;
        v = w >> (8 * lo);
        if (cnt < 4) begin
            v = v & ((32'd1 << (8 * cnt)) - 32'd1);
            if (rm[4] && v[8*cnt-1]) v = v | ~((32'd1 << (8 * cnt)) - 32'd1);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (wmem != 4'd0) begin
            chk("wr_addr_range", 32'(mem_addr < NW), 32'd1);
            if (mem_addr < NW)
                for (int i = 0; i < 4; i++)
                    mem[mem_addr[AW-1:0]][8*i +: 8] = wmem[i] ? store_data[8*i +: 8] : 8'h00;
        end
        if (rmem[3:0] != 4'd0) begin
            chk("rd_addr_range", 32'(mem_addr < NW), 32'd1);
            if (mem_addr < NW) load_data <= mem_read(mem[mem_addr[AW-1:0]], rmem);
        end
    end

    // Reference: byte-addressed view of ref_mem, latency from the access class
    task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output exp_t e);
        int n;
        longint unsigned base, last, ba;
        logic legal;
        logic [31:0] v;
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        base  = {32'd0, a};
        last  = (base + longint'(n) - 1) >> 2;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.acc   = 0;
        if (!legal || last >= NW) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            v = 32'd0;
            for (int k = 0; k < n; k++) begin
                ba = base + longint'(k);
                v[8*k +: 8] = ref_mem[int'(ba >> 2)][8*int'(ba % 4) +: 8];
            end
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            e.rdata = v;
            e.lat   = ((base >> 2) != last) ? 3 : 2;
        end else begin
            for (int k = 0; k < n; k++) begin
                ba = base + longint'(k);
                ref_mem[int'(ba >> 2)][8*int'(ba % 4) +: 8] = wd[8*k +: 8];
            end
            e.lat = (n == 4 && base % 4 == 0) ? 2 : (((base >> 2) != last) ? 5 : 3);
        end
    endtask

    // Monitor: pop the oldest expectation whenever a response appears
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && resp_valid) begin
            chk("resp_pending", 32'(exp_q.size() != 0), 32'd1);
            chk("resp_mem_idle", {23'd0, wmem, rmem}, 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > 8) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL resp_timeout: actual=no response after %0d cycles required latency=%0d",
                     cyc - e.acc + 1, e.lat);
        end
    end

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Waits for IDLE, waving junk requests at the busy DUT meanwhile
    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 40) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            @(posedge clk);
            #1;
            w++;
        end
        req_valid = 1'b0;
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: actual=req_ready low for %0d cycles required=high", w);
            finish_now();
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        exp_t e;
        wait_ready();
        ref_op(we, f3, a, wd, e);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        mem[w]     = v;
        ref_mem[w] = v;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        we;
        int          sel;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < NW; i++) poke(i, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", {29'd0, resp_valid, resp_err, 1'b0}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_ctl", {23'd0, wmem, rmem}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_store_data", store_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        poke(4, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        chk("lw_rmem", 32'(rmem), 32'h0F);
        chk("lw_mem_addr", mem_addr, 32'd4);
        wait_ready();
        poke(4, 32'h80FF0000);
        do_req(1'b0, 3'b000, 32'h13, 32'd0);
        chk("lb_rmem", 32'(rmem), 32'h18);
        do_req(1'b0, 3'b100, 32'h13, 32'd0);
        chk("lbu_rmem", 32'(rmem), 32'h08);
        wait_ready();
        poke(8, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h21, 32'h000000AB);
        chk("sb_rd_a", {rmem, mem_addr[26:0]}, {5'b01111, 27'd8});
        @(posedge clk);
        #1;
        chk("sb_wr_a_wmem", 32'(wmem), 32'hF);
        chk("sb_wr_a_data", store_data, 32'h1122AB44);
        wait_ready();
        poke(3, 32'h44332211);
        poke(4, 32'h88776655);
        do_req(1'b0, 3'b010, 32'h0E, 32'd0);
        wait_ready();
        poke(1, 32'h11223344);
        poke(2, 32'h55667788);
        do_req(1'b1, 3'b001, 32'h07, 32'h0000BEEF);
        wait_ready();
        chk("sh_span_word1", mem[1], 32'hEF223344);
        chk("sh_span_word2", mem[2], 32'h556677BE);
        do_req(1'b0, 3'b011, 32'h40, 32'd0);
        chk("err_f3_mem_ctl", {23'd0, wmem, rmem}, 32'd0);
        do_req(1'b0, 3'b010, 32'h20000, 32'd0);
        chk("err_range_mem_ctl", {23'd0, wmem, rmem}, 32'd0);
        do_req(1'b1, 3'b001, 32'h1FFFF, 32'h1234);
        do_req(1'b1, 3'b011, 32'h40, 32'h1234);

        // Reset while WR_B is presented: word A already written, word A+1 untouched
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h07;
        req_wdata = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ref_mem[1] = 32'h34223344;
        repeat (3) @(posedge clk);
        #1;
        chk("wr_b_wmem", 32'(wmem), 32'hF);
        chk("wr_b_addr", mem_addr, 32'd2);
        chk("wr_b_data", store_data, 32'h55667712);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_ctl", {23'd0, wmem, rmem}, 32'd0);
        chk("abort_store_data", store_data, 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_word_a", mem[1], 32'h34223344);
        chk("abort_word_b", mem[2], 32'h556677BE);

        for (int i = 0; i < 64; i++) poke(i, $urandom);
        for (int i = NW - 8; i < NW; i++) poke(i, $urandom);
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 85)      a = 32'($urandom_range(0, 255));
            else if (sel < 95) a = 32'h1FFE0 + 32'($urandom_range(0, 31));
            else               a = $urandom;
            we  = 1'($urandom);
            sel = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (we)                   f3 = 3'(sel % 3);
            else                           f3 = (sel > 2) ? 3'(sel + 1) : 3'(sel);
            do_req(we, f3, a, $urandom);
        end

        wait_ready();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        for (int i = NW - 8; i < NW; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        finish_now();
    end
endmodule
